// File: rtl/msrv32_machine_ctrl.sv
// msrv32 machine-mode control FSM: boot, trap entry and MRET return.
// Define MSRV32_INTERRUPTS_EN to enable external/software/timer interrupts.
module msrv32_machine_ctrl (
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic [6:0] opcode_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic [3:0] cause_out,
  output logic       i_or_e_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_t;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       flush_q, flush_d;
  logic       trap_q, trap_d;
  logic       mclr_q, mclr_d;
  logic       mset_q, mset_d;
  logic [3:0] cause_q, cause_d;
  logic       ioe_q, ioe_d;

  logic       sys, ecall, ebreak, mret;
  logic       exc, irq, trap;
  logic [3:0] exc_cause, irq_cause;

  always_comb begin
    sys = (opcode_in == 7'b1110011) && (funct3_in == 3'b000) &&
          (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    ecall  = sys && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    ebreak = sys && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    mret   = sys && (funct7_in == 7'b0011000) &&
             (rs2_addr_in == 5'b00010);
  end

  always_comb begin
    exc       = 1'b1;
    exc_cause = 4'd0;
    if (illegal_instr_in)         exc_cause = 4'd2;
    else if (misaligned_instr_in) exc_cause = 4'd0;
    else if (ecall)               exc_cause = 4'd11;
    else if (ebreak)              exc_cause = 4'd3;
    else if (misaligned_load_in)  exc_cause = 4'd4;
    else if (misaligned_store_in) exc_cause = 4'd6;
    else                          exc       = 1'b0;
  end

`ifdef MSRV32_INTERRUPTS_EN
  logic ext_q, sw_q, tmr_q;
  always_comb begin
    ext_q     = mie_in && meie_in && meip_in;
    sw_q      = mie_in && msie_in && msip_in;
    tmr_q     = mie_in && mtie_in && mtip_in;
    irq       = ext_q || sw_q || tmr_q;
    irq_cause = ext_q ? 4'd11 : (sw_q ? 4'd3 : 4'd7);
  end
`else
  logic unused_irq;
  assign unused_irq = ^{mie_in, meie_in, mtie_in, msie_in,
                        meip_in, mtip_in, msip_in};
  assign irq       = 1'b0;
  assign irq_cause = 4'd0;
`endif

  assign trap = exc || irq;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ioe_d   = ioe_q;
    unique case (state_q)
      RESET:       state_d = OPERATING;
      OPERATING: begin
        if (trap) begin
          state_d = TRAP_TAKEN;
          cause_d = exc ? exc_cause : irq_cause;
          ioe_d   = !exc;
        end else if (mret) begin
          state_d = TRAP_RETURN;
        end
      end
      TRAP_TAKEN:  state_d = OPERATING;
      TRAP_RETURN: state_d = OPERATING;
      default:     state_d = RESET;
    endcase
    if (ms_riscv32_mp_rst_in) begin
      state_d = RESET;
      cause_d = 4'd0;
      ioe_d   = 1'b0;
    end
  end

  // Outputs are registered as a function of the state being entered.
  always_comb begin
    pc_src_d = PC_NEXT;
    flush_d  = 1'b0;
    trap_d   = 1'b0;
    mclr_d   = 1'b0;
    mset_d   = 1'b0;
    unique case (state_d)
      RESET: begin
        pc_src_d = PC_BOOT;
        flush_d  = 1'b1;
      end
      TRAP_TAKEN: begin
        pc_src_d = PC_TRAP;
        flush_d  = 1'b1;
        trap_d   = 1'b1;
        mclr_d   = 1'b1;
      end
      TRAP_RETURN: begin
        pc_src_d = PC_EPC;
        flush_d  = 1'b1;
        mset_d   = 1'b1;
      end
      default: pc_src_d = PC_NEXT;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    state_q  <= state_d;
    pc_src_q <= pc_src_d;
    flush_q  <= flush_d;
    trap_q   <= trap_d;
    mclr_q   <= mclr_d;
    mset_q   <= mset_d;
    cause_q  <= cause_d;
    ioe_q    <= ioe_d;
  end

  assign pc_src_out      = pc_src_q;
  assign flush_out       = flush_q;
  assign trap_taken_out  = trap_q;
  assign set_epc_out     = trap_q;
  assign set_cause_out   = trap_q;
  assign mie_clear_out   = mclr_q;
  assign mie_set_out     = mset_q;
  assign cause_out       = cause_q;
`ifdef MSRV32_INTERRUPTS_EN
  assign i_or_e_out      = ioe_q;
`else
  assign i_or_e_out      = 1'b0;
`endif
  assign instret_inc_out = (state_q == OPERATING) && !trap && !mret;

endmodule

// File: tb/tb_msrv32_machine_ctrl.sv
// Scoreboard bench for msrv32_machine_ctrl: directed vectors queue
// expected outputs, a negedge monitor pops and compares.
module tb_msrv32_machine_ctrl;

`ifdef MSRV32_INTERRUPTS_EN
  localparam bit I = 1'b1;
`else
  localparam bit I = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic       ill, mis_i, mis_l, mis_s;
  logic       mie, meie, mtie, msie, meip, mtip, msip;
  logic [1:0] pc_src;
  logic       flush, trap_taken, set_epc, set_cause;
  logic [3:0] cause;
  logic       ioe, mclr, mset, instret;

  always #5 clk = ~clk;

  msrv32_machine_ctrl dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .opcode_in(opcode),
    .funct3_in(funct3),
    .funct7_in(funct7),
    .rs1_addr_in(rs1),
    .rs2_addr_in(rs2),
    .rd_addr_in(rd),
    .illegal_instr_in(ill),
    .misaligned_instr_in(mis_i),
    .misaligned_load_in(mis_l),
    .misaligned_store_in(mis_s),
    .mie_in(mie),
    .meie_in(meie),
    .mtie_in(mtie),
    .msie_in(msie),
    .meip_in(meip),
    .mtip_in(mtip),
    .msip_in(msip),
    .pc_src_out(pc_src),
    .flush_out(flush),
    .trap_taken_out(trap_taken),
    .set_epc_out(set_epc),
    .set_cause_out(set_cause),
    .cause_out(cause),
    .i_or_e_out(ioe),
    .mie_clear_out(mclr),
    .mie_set_out(mset),
    .instret_inc_out(instret)
  );

  typedef struct packed {
    logic        rst, ill, mld, mret, mie, meie, meip, mtie, mtip;
    logic [14:0] exp;
  } vec_t;

  typedef struct packed {
    int          idx;
    logic [14:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  function automatic logic [14:0] ex(logic [1:0] pc, logic fl, logic tr,
                                     logic [3:0] c, logic io, logic ms,
                                     logic inc);
    return {pc, fl, tr, tr, tr, c, io, tr, ms, inc};
  endfunction

  function automatic logic [14:0] R();
    return ex(2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [14:0] O(logic [3:0] c, logic io, logic inc);
    return ex(2'd3, 1'b0, 1'b0, c, io, 1'b0, inc);
  endfunction
  function automatic logic [14:0] T(logic [3:0] c, logic io);
    return ex(2'd2, 1'b1, 1'b1, c, io, 1'b0, 1'b0);
  endfunction
  function automatic logic [14:0] Rt(logic [3:0] c, logic io);
    return ex(2'd1, 1'b1, 1'b0, c, io, 1'b1, 1'b0);
  endfunction

  // fields: rst ill mld mret mie meie meip mtie mtip exp
  function automatic vec_t v(logic r, logic il, logic ml, logic mr,
                             logic e, logic ee, logic ep, logic te,
                             logic tp, logic [14:0] x);
    return '{r, il, ml, mr, e, ee, ep, te, tp, x};
  endfunction

  initial begin
    logic [3:0] c1, c2;
    c1 = I ? 4'd7 : 4'd2;
    c2 = I ? 4'd11 : 4'd4;
    vecs.push_back(v(1,0,0,0, 0,0,0,0,0, R()));
    vecs.push_back(v(1,0,0,0, 0,0,0,0,0, R()));
    vecs.push_back(v(1,0,0,0, 0,0,0,0,0, R()));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, R()));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, O(4'd0, 1'b0, 1'b1)));
    vecs.push_back(v(0,1,0,0, 0,0,0,0,0, O(4'd0, 1'b0, 1'b0)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, T(4'd2, 1'b0)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, O(4'd2, 1'b0, 1'b1)));
    vecs.push_back(v(0,0,0,0, 1,0,0,1,1, O(4'd2, 1'b0, !I)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0,
                     I ? T(4'd7, 1'b1) : O(4'd2, 1'b0, 1'b1)));
    vecs.push_back(v(0,0,0,0, 0,0,0,1,1, O(c1, I, 1'b1)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, O(c1, I, 1'b1)));
    vecs.push_back(v(0,0,0,1, 0,0,0,0,0, O(c1, I, 1'b0)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, Rt(c1, I)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, O(c1, I, 1'b1)));
    vecs.push_back(v(0,0,1,0, 1,1,1,0,0, O(c1, I, 1'b0)));
    vecs.push_back(v(0,0,0,0, 1,1,1,0,0, T(4'd4, 1'b0)));
    vecs.push_back(v(0,0,0,0, 1,1,1,0,0, O(4'd4, 1'b0, !I)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0,
                     I ? T(4'd11, 1'b1) : O(4'd4, 1'b0, 1'b1)));
    vecs.push_back(v(0,1,0,1, 0,0,0,0,0, O(c2, I, 1'b0)));
    vecs.push_back(v(1,0,0,0, 0,0,0,0,0, T(4'd2, 1'b0)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, R()));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, O(4'd0, 1'b0, 1'b1)));
    vecs.push_back(v(0,1,0,0, 0,0,0,0,0, O(4'd0, 1'b0, 1'b0)));
    vecs.push_back(v(0,1,0,0, 0,0,0,0,0, T(4'd2, 1'b0)));
    vecs.push_back(v(0,1,0,0, 0,0,0,0,0, O(4'd2, 1'b0, 1'b0)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, T(4'd2, 1'b0)));
    vecs.push_back(v(0,0,0,0, 0,0,0,0,0, O(4'd2, 1'b0, 1'b1)));
  end

  task automatic apply(vec_t x);
    rst  = x.rst;
    ill  = x.ill;
    mis_l = x.mld;
    mie  = x.mie;
    meie = x.meie;
    meip = x.meip;
    mtie = x.mtie;
    mtip = x.mtip;
    if (x.mret) begin
      opcode = 7'h73; funct3 = 3'd0; funct7 = 7'h18;
      rs1 = 5'd0; rs2 = 5'd2; rd = 5'd0;
    end else begin
      opcode = 7'h13; funct3 = 3'd0; funct7 = 7'h00;
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd1;
    end
  endtask

  initial begin
    rst = 1'b1;
    ill = 0; mis_i = 0; mis_l = 0; mis_s = 0;
    mie = 0; meie = 0; mtie = 0; msie = 0;
    meip = 0; mtip = 0; msip = 0;
    opcode = 7'h13; funct3 = 0; funct7 = 0;
    rs1 = 0; rs2 = 0; rd = 0;
    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vecs[i]);
      sb.push_back('{i, vecs[i].exp});
    end
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    done = 1'b1;
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [14:0] act;
      e = sb.pop_front();
      act = {pc_src, flush, trap_taken, set_epc, set_cause, cause,
             ioe, mclr, mset, instret};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL vec%0d: got=%b required=%b", e.idx, act, e.exp);
      end
    end
  end

  initial begin
    fork
      wait (done);
      #5000;
    join_any
    if (!done) begin
      failures++;
      $display("FAIL timeout: done=0 required=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
